// File: rtl/seq_comparator.sv
`default_nettype none
// ============================================================================
//  Module   : seq_comparator
//  Purpose  : Multi-cycle N-bit magnitude comparator scanning CHUNK-bit slices
//             MSB first, with early exit and optional two's-complement mode.
//  Revision : 1.0  initial release
// ============================================================================
module seq_comparator #(
    parameter int N     = 32,
    parameter int CHUNK = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         signed_mode,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         busy,
    output logic         done,
    output logic         gr,
    output logic         lo,
    output logic         eq
);

    localparam int             c_nch  = N / CHUNK;
    localparam int             c_cw   = (c_nch > 1) ? $clog2(c_nch) : 1;
    localparam logic [c_cw-1:0] c_last = c_cw'(c_nch - 1);
    // Flipping the sign bit maps two's-complement order onto unsigned order.
    localparam logic [N-1:0]   c_msb  = N'(1) << (N - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CMP  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [N-1:0]    r_sa;
    logic [N-1:0]    r_sb;
    logic [c_cw-1:0] r_cnt;
    logic            r_gr;
    logic            r_lo;
    logic            r_eq;

    logic [CHUNK-1:0] w_ta;
    logic [CHUNK-1:0] w_tb;
    logic             w_differ;
    logic             w_last;
    logic             w_launch;

    assign w_ta     = r_sa[N-1 -: CHUNK];
    assign w_tb     = r_sb[N-1 -: CHUNK];
    assign w_differ = (w_ta != w_tb);
    assign w_last   = (r_cnt == c_last);
    assign w_launch = start && ((r_state == S_IDLE) || (r_state == S_DONE));

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_nxt = S_CMP;
            S_CMP:   if (w_differ || w_last) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = start ? S_CMP : S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_sa    <= '0;
            r_sb    <= '0;
            r_cnt   <= '0;
            r_gr    <= 1'b0;
            r_lo    <= 1'b0;
            r_eq    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_launch) begin
                r_sa  <= signed_mode ? (a ^ c_msb) : a;
                r_sb  <= signed_mode ? (b ^ c_msb) : b;
                r_cnt <= '0;
            end else if (r_state == S_CMP) begin
                if (w_differ) begin
                    r_gr <= (w_ta > w_tb);
                    r_lo <= (w_ta < w_tb);
                    r_eq <= 1'b0;
                end else if (w_last) begin
                    r_gr <= 1'b0;
                    r_lo <= 1'b0;
                    r_eq <= 1'b1;
                end else begin
                    r_sa  <= r_sa << CHUNK;
                    r_sb  <= r_sb << CHUNK;
                    r_cnt <= r_cnt + c_cw'(1);
                end
            end
        end
    end

    assign busy = (r_state == S_CMP);
    assign done = (r_state == S_DONE);
    assign gr   = r_gr;
    assign lo   = r_lo;
    assign eq   = r_eq;

endmodule
`default_nettype wire

// File: tb/tb_seq_comparator.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seq_comparator
//  Purpose  : Self-checking bench for seq_comparator over four (N, CHUNK) sets.
//  Revision : 1.0  initial release
// ============================================================================
module tb_seq_comparator;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        sm;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  busy_v, done_v, gr_v, lo_v, eq_v;
    int          n_chk  = 0;
    int          n_pass = 0;

    always #5 clk = ~clk;

    seq_comparator #(.N(32), .CHUNK(8)) u_dut0 (
        .clk(clk), .rst(rst), .start(start), .signed_mode(sm), .a(a), .b(b),
        .busy(busy_v[0]), .done(done_v[0]), .gr(gr_v[0]), .lo(lo_v[0]), .eq(eq_v[0]));
    seq_comparator #(.N(32), .CHUNK(32)) u_dut1 (
        .clk(clk), .rst(rst), .start(start), .signed_mode(sm), .a(a), .b(b),
        .busy(busy_v[1]), .done(done_v[1]), .gr(gr_v[1]), .lo(lo_v[1]), .eq(eq_v[1]));
    seq_comparator #(.N(32), .CHUNK(1)) u_dut2 (
        .clk(clk), .rst(rst), .start(start), .signed_mode(sm), .a(a), .b(b),
        .busy(busy_v[2]), .done(done_v[2]), .gr(gr_v[2]), .lo(lo_v[2]), .eq(eq_v[2]));
    seq_comparator #(.N(16), .CHUNK(4)) u_dut3 (
        .clk(clk), .rst(rst), .start(start), .signed_mode(sm), .a(a[15:0]), .b(b[15:0]),
        .busy(busy_v[3]), .done(done_v[3]), .gr(gr_v[3]), .lo(lo_v[3]), .eq(eq_v[3]));

    function automatic int n_of(input int k);
        return (k == 3) ? 16 : 32;
    endfunction

    function automatic int c_of(input int k);
        case (k)
            0:       return 8;
            1:       return 32;
            2:       return 1;
            default: return 4;
        endcase
    endfunction

    // Reference: numeric compare for the flags, slice scan of the (sign-flipped) values for m.
    function automatic void model(input int k, input logic msm, input logic [31:0] va,
                                  input logic [31:0] vb, output int m,
                                  output logic g, output logic l, output logic e);
        int          n = n_of(k);
        int          c = c_of(k);
        logic [63:0] mask = (64'd1 << n) - 64'd1;
        logic [63:0] ma = {32'd0, va} & mask;
        logic [63:0] mb = {32'd0, vb} & mask;
        logic [63:0] fa, fb, sla, slb;
        longint      sa = longint'(ma);
        longint      sb = longint'(mb);
        if (msm && ma[n-1]) sa = sa - (longint'(1) << n);
        if (msm && mb[n-1]) sb = sb - (longint'(1) << n);
        g = (sa > sb);
        l = (sa < sb);
        e = (sa == sb);
        fa = msm ? (ma ^ (64'd1 << (n - 1))) : ma;
        fb = msm ? (mb ^ (64'd1 << (n - 1))) : mb;
        m = n / c;
        for (int j = 0; j < n / c; j++) begin
            sla = (fa >> (n - (j + 1) * c)) & ((64'd1 << c) - 64'd1);
            slb = (fb >> (n - (j + 1) * c)) & ((64'd1 << c) - 64'd1);
            if (sla != slb) begin
                m = j + 1;
                break;
            end
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Launch one compare on instance k; lat is the cycle of done (start cycle = 0), -1 on timeout.
    task automatic do_cmp(input int k, input logic msm, input logic [31:0] va,
                          input logic [31:0] vb, output int lat, output int busy_bad,
                          output logic g, output logic l, output logic e);
        int w = 0;
        while (busy_v[k] && w < 40) begin
            tick();
            w++;
        end
        start = 1'b1; sm = msm; a = va; b = vb;
        tick();
        start = 1'b0; sm = $urandom_range(0, 1); a = $urandom; b = $urandom;
        lat = 1;
        busy_bad = 0;
        while (!done_v[k] && lat < 40) begin
            if (!busy_v[k]) busy_bad++;
            tick();
            lat++;
        end
        if (!done_v[k]) lat = -1;
        g = gr_v[k]; l = lo_v[k]; e = eq_v[k];
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; sm = 1'b0; a = 32'd1; b = 32'd0;
        tick();
        tick();
        n_chk++; if (busy_v !== 4'b0) $display("FAIL reset_busy: got %b expected 0000", busy_v); else n_pass++;
        n_chk++; if (done_v !== 4'b0) $display("FAIL reset_done: got %b expected 0000", done_v); else n_pass++;
        n_chk++; if (gr_v !== 4'b0) $display("FAIL reset_gr: got %b expected 0000", gr_v); else n_pass++;
        n_chk++; if (lo_v !== 4'b0) $display("FAIL reset_lo: got %b expected 0000", lo_v); else n_pass++;
        n_chk++; if (eq_v !== 4'b0) $display("FAIL reset_eq: got %b expected 0000", eq_v); else n_pass++;
        rst = 1'b0; start = 1'b0;
        tick();
        n_chk++; if (busy_v !== 4'b0) $display("FAIL reset_nostart: busy %b expected 0000", busy_v); else n_pass++;
    endtask

    task automatic test_directed();
        logic [31:0] ta [7] = '{32'h0, 32'h1, 32'h1234_5678, 32'h8000_0000,
                                32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000};
        logic [31:0] tb [7] = '{32'h1, 32'h0, 32'h1234_5678, 32'h7FFF_FFFF,
                                32'h1, 32'h1, 32'h7FFF_FFFF};
        logic        ts [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        int          tl [7] = '{5, 5, 5, 2, 2, 2, 2};
        logic [2:0]  tf [7] = '{3'b010, 3'b100, 3'b001, 3'b100, 3'b010, 3'b100, 3'b010};
        int          lat, bb;
        logic        g, l, e;
        for (int i = 0; i < 7; i++) begin
            do_cmp(0, ts[i], ta[i], tb[i], lat, bb, g, l, e);
            n_chk++; if (lat !== tl[i]) $display("FAIL dir_lat[%0d]: got %0d expected %0d", i, lat, tl[i]); else n_pass++;
            n_chk++; if ({g, l, e} !== tf[i]) $display("FAIL dir_flags[%0d]: got %b expected %b", i, {g, l, e}, tf[i]); else n_pass++;
            n_chk++; if (bb !== 0) $display("FAIL dir_busy[%0d]: %0d cycles low, expected 0", i, bb); else n_pass++;
        end
    endtask

    task automatic test_busy_ignore();
        int lat = 1;
        tick();
        start = 1'b1; sm = 1'b0; a = 32'h0000_0005; b = 32'h0000_0003;
        tick();
        start = 1'b0;
        tick();
        start = 1'b1; sm = 1'b1; a = 32'h0; b = 32'hFFFF_FFFF;
        tick();
        start = 1'b0;
        lat = 3;
        while (!done_v[0] && lat < 40) begin
            tick();
            lat++;
        end
        n_chk++; if (lat !== 5) $display("FAIL ignore_lat: got %0d expected 5", lat); else n_pass++;
        n_chk++; if ({gr_v[0], lo_v[0], eq_v[0]} !== 3'b100) $display("FAIL ignore_flags: got %b expected 100", {gr_v[0], lo_v[0], eq_v[0]}); else n_pass++;
        tick();
        n_chk++; if (done_v[0] !== 1'b0) $display("FAIL ignore_pulse: done %b expected 0", done_v[0]); else n_pass++;
        n_chk++; if (gr_v[0] !== 1'b1) $display("FAIL ignore_hold: gr %b expected 1", gr_v[0]); else n_pass++;
    endtask

    task automatic test_back_to_back();
        tick();
        start = 1'b1; sm = 1'b0; a = 32'hA5A5_0F0F; b = 32'hA5A5_0F0F;
        for (int cyc = 1; cyc <= 15; cyc++) begin
            tick();
            n_chk++; if (done_v[0] !== (cyc % 5 == 0)) $display("FAIL b2b_done[%0d]: got %b expected %b", cyc, done_v[0], (cyc % 5 == 0)); else n_pass++;
            if (cyc >= 5) begin
                n_chk++; if (eq_v[0] !== 1'b1) $display("FAIL b2b_eq[%0d]: got %b expected 1", cyc, eq_v[0]); else n_pass++;
            end
        end
        start = 1'b0;
        tick();
    endtask

    task automatic test_abort();
        int   lat, bb;
        logic g, l, e;
        start = 1'b1; sm = 1'b0; a = 32'h1234_5678; b = 32'h1234_5678;
        tick();
        start = 1'b0;
        tick();
        tick();
        n_chk++; if (busy_v[0] !== 1'b1 || done_v[0] !== 1'b0) $display("FAIL abort_c3: busy %b done %b expected 1 0", busy_v[0], done_v[0]); else n_pass++;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_chk++; if ({busy_v, done_v} !== 8'b0) $display("FAIL abort_bd: got %b expected 0", {busy_v, done_v}); else n_pass++;
        n_chk++; if ({gr_v, lo_v, eq_v} !== 12'b0) $display("FAIL abort_flags: got %b expected 0", {gr_v, lo_v, eq_v}); else n_pass++;
        do_cmp(0, 1'b0, 32'd3, 32'd7, lat, bb, g, l, e);
        n_chk++; if (lat !== 5) $display("FAIL abort_relat: got %0d expected 5", lat); else n_pass++;
        n_chk++; if ({g, l, e} !== 3'b010) $display("FAIL abort_reflags: got %b expected 010", {g, l, e}); else n_pass++;
    endtask

    task automatic test_sweep();
        logic [31:0] da [4] = '{32'h0, 32'h1, 32'h1234_5678, 32'h8000_0000};
        logic [31:0] db [4] = '{32'h1, 32'h0, 32'h1234_5678, 32'h7FFF_FFFF};
        logic [31:0] va, vb;
        logic        vs, g, l, e, xg, xl, xe;
        int          lat, bb, m, n;
        for (int k = 0; k < 4; k++) begin
            n = n_of(k);
            for (int i = 0; i < 1008; i++) begin
                if (i < 8) begin
                    va = (n == 16) ? (da[i % 4] >> 16) | (da[i % 4] & 32'h1) : da[i % 4];
                    vb = (n == 16) ? (db[i % 4] >> 16) | (db[i % 4] & 32'h1) : db[i % 4];
                    vs = (i >= 4);
                end else begin
                    va = $urandom;
                    case ($urandom_range(0, 3))
                        0:       vb = va;
                        1:       vb = va ^ (32'd1 << $urandom_range(0, n - 1));
                        default: vb = $urandom;
                    endcase
                    vs = $urandom_range(0, 1);
                end
                model(k, vs, va, vb, m, xg, xl, xe);
                do_cmp(k, vs, va, vb, lat, bb, g, l, e);
                n_chk++; if (lat !== 1 + m) $display("FAIL sweep_lat k%0d: a=%h b=%h s=%b got %0d expected %0d", k, va, vb, vs, lat, 1 + m); else n_pass++;
                n_chk++; if ({g, l, e} !== {xg, xl, xe}) $display("FAIL sweep_flags k%0d: a=%h b=%h s=%b got %b expected %b", k, va, vb, vs, {g, l, e}, {xg, xl, xe}); else n_pass++;
                n_chk++; if (bb !== 0) $display("FAIL sweep_busy k%0d: %0d cycles low, expected 0", k, bb); else n_pass++;
            end
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; sm = 1'b0; a = '0; b = '0;
        test_reset();
        test_directed();
        test_busy_ignore();
        test_back_to_back();
        test_abort();
        test_sweep();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/seq_comparator.md
# seq_comparator

Multi-cycle, parametrised magnitude comparator and the successor to the single-cycle N-bit comparator. It compares two N-bit operands in CHUNK-bit slices, MSB slice first, and stops at the first slice that differs. It supports unsigned and two's-complement signed modes through a start/busy/done handshake. It serves wide-operand datapaths where a full-width single-cycle compare would limit timing.

## Interface
Parameters:
- N, 32, operand width in bits; must be a multiple of CHUNK.
- CHUNK, 8, slice width compared per cycle; 1 ≤ CHUNK ≤ N. NCH = N/CHUNK.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a compare; sampled only when not busy.
- signed_mode  input  1  1 = two's-complement compare, 0 = unsigned; sampled with start.
- a  input  N  operand A; sampled with start.
- b  input  N  operand B; sampled with start.
- busy  output  1  high while the compare is in progress (state CMP).
- done  output  1  one-cycle pulse; result valid.
- gr  output  1  a > b.
- lo  output  1  a < b.
- eq  output  1  a == b.

## Operation
- Clock and reset are fixed: one clock, clk; reset rst is synchronous and active-high.
- States:
  - IDLE: waiting for start.
  - CMP: scanning slices.
  - DONE: result cycle.
- IDLE/DONE → CMP when start=1. On that edge:
  - Latch a and b into internal shift registers.
  - If signed_mode=1, invert bit N-1 of both latched copies. Unsigned compare of the flipped values then equals the signed compare.
  - Load the slice counter with 0.
- CMP, slice j (j=0 is the MSB slice): compare the top CHUNK bits of each shift register, unsigned.
  - Slices differ: register gr/lo from that slice, eq=0, go to DONE.
  - Slices equal and j < NCH-1: shift both registers left by CHUNK, increment j, stay in CMP.
  - Slices equal and j = NCH-1: register eq=1, gr=lo=0, go to DONE.
- DONE → IDLE when start=0; → CMP when start=1, giving back-to-back operation.
- start while in CMP is ignored: no queueing, and the in-flight operands are unaffected.
- a, b and signed_mode are don't-care outside the start-sampling edge.
- Results:
  - gr/lo/eq hold their value from DONE until the next DONE.
  - After the first completed compare, exactly one of them is high.
  - Before any compare since reset, all three are 0.
- CHUNK=N degenerates to one CMP cycle per compare.

## Timing
- Reset (rst=1 at an edge) sets: state IDLE, busy=0, done=0, gr=0, lo=0, eq=0, internal registers 0.
- Reset has priority over start.
- Reset during CMP aborts the compare; no done is produced.
- Latency: start high in cycle 0 → done high in cycle 1+m. m = slices examined, from 1 (MSB slice differs) to NCH (equal, or only the LSB slice differs).
- busy is high in cycles 1..m.
- done is high exactly in cycle 1+m, and gr/lo/eq take their new values in that same cycle.
- Throughput with start held high: one result every m+1 cycles.
- No combinational path from inputs to outputs; all outputs are registered.

## Test plan
- Reset: hold rst 2 cycles, with start=1 during reset → busy=done=gr=lo=eq=0, no compare starts.
- Unsigned, N=32, CHUNK=8:
  - a=0, b=1 → done in cycle 5, lo=1.
  - a=1, b=0 → done in cycle 5, gr=1.
  - a=b=0x1234_5678 → done in cycle 5, eq=1.
  - a=0x8000_0000, b=0x7FFF_FFFF → done in cycle 2 (early exit), gr=1.
- Signed mode: a=0xFFFF_FFFF (−1), b=1, signed_mode=1 → lo=1. Same operands with signed_mode=0 → gr=1. a=0x8000_0000, b=0x7FFF_FFFF, signed_mode=1 → lo=1, done in cycle 2.
- Handshake:
  - Pulse start again, with different a/b, while busy=1 → ignored; the result matches the first operands.
  - Hold start=1 continuously with a=b → done pulses every 5 cycles, eq stays 1.
- Abort: assert rst in cycle 3 of an equal compare → no done pulse, all outputs 0 next cycle. A new start afterwards completes normally.
- Parameter sweep: repeat the unsigned and signed cases for (N, CHUNK) = (32,32), (32,1), (16,4). Check latency 1+m and against a reference $signed/$unsigned compare over 1000 random vectors per configuration.
